rv32i_pipe_ctrl: RTL

Parametrised pipeline control and hazard unit for the rv32i in-order pipeline. It generalises the fixed 5-stage hold/flush plumbing to a configurable post-ID depth, redirect stage and load-result stage. It keeps a shadow tracker of in-flight destination registers and produces ID stall, IF/ID flush, per-operand forwarding selects and performance counters. It sits beside the core datapath; the pipeline registers consume its hold/flush outputs.

---
 rtl/rv32i_core_pkg.sv | 21 ++
 rtl/rv32i_hazard_match.sv | 29 ++
 rtl/rv32i_pipe_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rv32i_core_pkg.sv
// Shared types for rv32i pipeline control: in-flight tracker entry and forwarding constants.
package rv32i_core_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } pipe_trk_entry_t;

  localparam pipe_trk_entry_t TRK_BUBBLE = '0;

  // x0 is hardwired, so a zero source never matches an in-flight writer.
  function automatic logic trk_match(input pipe_trk_entry_t e, input logic [REG_AW-1:0] rs);
    return (rs != '0) && e.valid && e.we && (e.rd == rs);
  endfunction

endpackage

// File: rtl/rv32i_hazard_match.sv
// Youngest-match priority encoder over the in-flight tracker for one source operand.
module rv32i_hazard_match
  import rv32i_core_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDXW  = $clog2(DEPTH)
) (
  input  pipe_trk_entry_t [DEPTH-1:0] trk_i,
  input  logic [REG_AW-1:0]           rs_i,
  output logic                        hit_o,
  output logic [IDXW-1:0]             idx_o,
  output logic                        is_load_o
);

  // Scan oldest to youngest so the lowest-index match is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (trk_match(trk_i[i], rs_i)) begin
        hit_o     = 1'b1;
        idx_o     = IDXW'(i);
        is_load_o = trk_i[i].is_load;
      end
    end
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline hold/flush/forwarding control with an in-flight destination tracker.
// Forwarding is enabled by defining RV32I_PIPE_CTRL_FWD_EN; otherwise every RAW match stalls.
module rv32i_pipe_ctrl
  import rv32i_core_pkg::*;
#(
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned REDIRECT_STAGE = 0,
  parameter int unsigned LOAD_STAGE     = 1,
  parameter int unsigned SELW           = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic              id_rd_we_i,
  input  logic              id_is_load_i,
  input  logic              redirect_i,
  input  logic              mem_hold_i,
  output logic              stall_id_o,
  output logic              hold_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic [SELW-1:0]   fwd_rs1_sel_o,
  output logic [SELW-1:0]   fwd_rs2_sel_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam int unsigned IDXW = $clog2(DEPTH);

  pipe_trk_entry_t [DEPTH-1:0] trk_q, trk_d;
  logic [31:0]                 stall_cnt_q, stall_cnt_d;
  logic [31:0]                 flush_cnt_q, flush_cnt_d;

  logic            hit1_c, ld1_c, hit2_c, ld2_c;
  logic [IDXW-1:0] idx1_c, idx2_c;
  logic            haz1_c, haz2_c;
  logic [SELW-1:0] sel1_c, sel2_c;
  logic            redir_acc_c, stall_c, id_accept_c;
  pipe_trk_entry_t id_entry_c;

  rv32i_hazard_match #(.DEPTH(DEPTH), .IDXW(IDXW)) u_match_rs1 (
    .trk_i     (trk_q),
    .rs_i      (id_rs1_addr_i),
    .hit_o     (hit1_c),
    .idx_o     (idx1_c),
    .is_load_o (ld1_c)
  );

  rv32i_hazard_match #(.DEPTH(DEPTH), .IDXW(IDXW)) u_match_rs2 (
    .trk_i     (trk_q),
    .rs_i      (id_rs2_addr_i),
    .hit_o     (hit2_c),
    .idx_o     (idx2_c),
    .is_load_o (ld2_c)
  );

`ifdef RV32I_PIPE_CTRL_FWD_EN
  // Load data only exists from LOAD_STAGE onward; younger load producers must stall.
  assign haz1_c = hit1_c & ld1_c & (32'(idx1_c) < LOAD_STAGE);
  assign haz2_c = hit2_c & ld2_c & (32'(idx2_c) < LOAD_STAGE);
  assign sel1_c = hit1_c ? SELW'(idx1_c) + SELW'(1) : SELW'(FWD_SEL_RF);
  assign sel2_c = hit2_c ? SELW'(idx2_c) + SELW'(1) : SELW'(FWD_SEL_RF);
`else
  logic fwd_unused_c;
  assign fwd_unused_c = ^{idx1_c, idx2_c, ld1_c, ld2_c};
  assign haz1_c = hit1_c;
  assign haz2_c = hit2_c;
  assign sel1_c = SELW'(FWD_SEL_RF);
  assign sel2_c = SELW'(FWD_SEL_RF);
`endif

  assign redir_acc_c = redirect_i & ~mem_hold_i;
  assign stall_c     = id_valid_i & (haz1_c | haz2_c) & ~redir_acc_c;
  assign id_accept_c = id_valid_i & ~stall_c & ~redir_acc_c;
  assign id_entry_c  = '{valid: 1'b1, we: id_rd_we_i, is_load: id_is_load_i, rd: id_rd_addr_i};

  // Tracker advance, redirect squash and partial freeze under MEM back-pressure.
  always_comb begin
    trk_d = trk_q;
    if (!mem_hold_i) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) trk_d[i] = trk_q[i-1];
      trk_d[0] = id_accept_c ? id_entry_c : TRK_BUBBLE;
      if (redir_acc_c) begin
        for (int i = 1; i <= int'(REDIRECT_STAGE); i++) trk_d[i] = TRK_BUBBLE;
      end
    end else begin
      for (int i = int'(LOAD_STAGE) + 1; i < int'(DEPTH); i++) begin
        trk_d[i] = (i == int'(LOAD_STAGE) + 1) ? TRK_BUBBLE : trk_q[i-1];
      end
    end
  end

  assign stall_cnt_d = stall_cnt_q + 32'(stall_c & ~mem_hold_i);
  assign flush_cnt_d = flush_cnt_q + 32'(redir_acc_c);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hold_o        = mem_hold_i;
  assign stall_id_o    = rst_ni & stall_c;
  assign flush_if_o    = rst_ni & redir_acc_c;
  assign flush_id_o    = rst_ni & redir_acc_c;
  assign fwd_rs1_sel_o = rst_ni ? sel1_c : '0;
  assign fwd_rs2_sel_o = rst_ni ? sel2_c : '0;
  assign stall_cnt_o   = rst_ni ? stall_cnt_q : '0;
  assign flush_cnt_o   = rst_ni ? flush_cnt_q : '0;

endmodule
